// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg : shared constants, state encoding and helpers for div_16by16 (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package div_pkg;

   localparam int WIDTH = 16;
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Two's-complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1) as unsigned.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step : one combinational restoring-division step (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             qbit_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // Partial remainder is always below the divisor, so the trial never needs more than WIDTH+1 bits.
   always_comb begin
      shifted = {rem_i, bit_i};
      trial   = shifted - {1'b0, divisor_i};
      qbit_o  = ~trial[WIDTH];
      rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   end

endmodule

`default_nettype wire

// File: rtl/div_16by16.sv
// ----------------------------------------------------------------------------
// div_16by16 : sequential restoring divider, one quotient bit per clock (rev 1.0)
// Optional macro DIV_SIGNED_EN selects two's-complement operands.
// ----------------------------------------------------------------------------
`default_nettype none

module div_16by16
   import div_pkg::*;
#(
   parameter int WIDTH = div_pkg::WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o,
   output logic             dz_o
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [WIDTH-1:0]   prem_q,  prem_d;
   logic [WIDTH-1:0]   dvd_q,   dvd_d;
   logic [WIDTH-1:0]   dvs_q,   dvs_d;
   logic [WIDTH-1:0]   quot_q,  quot_d;
   logic [WIDTH-1:0]   rem_q,   rem_d;
   logic               dz_q,    dz_d;
`ifdef DIV_SIGNED_EN
   logic               qneg_q,  qneg_d;
   logic               rneg_q,  rneg_d;
`endif

   logic [WIDTH-1:0]   step_rem;
   logic               step_qbit;
   logic [WIDTH-1:0]   qres;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (prem_q),
      .bit_i     (dvd_q[WIDTH-1]),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .qbit_o    (step_qbit)
   );

   assign qres = {dvd_q[WIDTH-2:0], step_qbit};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prem_d  = prem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               if (divisor_i == '0) begin
                  quot_d  = '1;
                  rem_d   = dividend_i;
                  dz_d    = 1'b1;
                  state_d = S_DONE;
               end else begin
`ifdef DIV_SIGNED_EN
                  dvd_d  = mag(dividend_i);
                  dvs_d  = mag(divisor_i);
                  qneg_d = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
                  rneg_d = dividend_i[WIDTH-1];
`else
                  dvd_d  = dividend_i;
                  dvs_d  = divisor_i;
`endif
                  prem_d  = '0;
                  cnt_d   = '0;
                  state_d = S_RUN;
               end
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            prem_d = step_rem;
            dvd_d  = qres;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) begin
`ifdef DIV_SIGNED_EN
               quot_d = qneg_q ? -qres : qres;
               rem_d  = rneg_q ? -step_rem : step_rem;
`else
               quot_d = qres;
               rem_d  = step_rem;
`endif
               dz_d    = 1'b0;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         prem_q  <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

   assign busy_o = (state_q == S_RUN);
   assign done_o = (state_q == S_DONE);
   assign quot_o = quot_q;
   assign rem_o  = rem_q;
   assign dz_o   = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_div_16by16.sv
// ----------------------------------------------------------------------------
// tb_div_16by16 : self-checking bench for div_16by16 against an arithmetic model (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_div_16by16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] dvd = '0;
   logic [15:0] dvs = '0;
   logic        busy, done, dz;
   logic [15:0] quot, rem;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_16by16 dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .dividend_i (dvd),
      .divisor_i  (dvs),
      .busy_o     (busy),
      .done_o     (done),
      .quot_o     (quot),
      .rem_o      (rem),
      .dz_o       (dz)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a request is honoured when not busy; quotient/remainder come from plain / and %.
   bit          m_init = 1'b0;
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   int          m_steps = 0;
   logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
   logic        m_dz = 1'b0;

   always @(posedge clk) begin
      if (!rst) begin
         m_init = 1'b1;
         m_busy = 1'b0;
         m_done = 1'b0;
         m_q = '0; m_r = '0; m_dz = 1'b0;
      end else if (m_busy) begin
         m_steps++;
         if (m_steps == 16) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_q = p_q; m_r = p_r; m_dz = 1'b0;
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            if (dvs == 16'h0) begin
               m_done = 1'b1;
               m_q = 16'hFFFF; m_r = dvd; m_dz = 1'b1;
            end else begin
`ifdef DIV_SIGNED_EN
               int a, b;
               a = int'($signed(dvd));
               b = int'($signed(dvs));
               p_q = 16'(a / b);
               p_r = 16'(a % b);
`else
               p_q = dvd / dvs;
               p_r = dvd % dvs;
`endif
               m_busy  = 1'b1;
               m_steps = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("busy_o", busy, m_busy);
         chk("done_o", done, m_done);
         if (!m_busy) begin
            chk("quot_o", quot, m_q);
            chk("rem_o",  rem,  m_r);
            chk("dz_o",   dz,   m_dz);
         end
      end
   end

   // Issue one division from IDLE/DONE and check latency and result against literals.
   task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq,
                      input logic [15:0] er, input logic edz, input int lat);
      int n;
      start = 1'b1; dvd = a; dvs = b;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      if (lat > 1) chk("busy_after_start", busy, 1'b1);
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, lat);
      chk("lit_quot", quot, eq);
      chk("lit_rem",  rem,  er);
      chk("lit_dz",   dz,   edz);
   endtask

   initial begin
      int n, dcount;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      chk("reset_quot", quot, 16'h0);
      chk("reset_busy", busy, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);

      run(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
      run(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17);
      repeat (2) @(posedge clk); #1;
      run(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1);
      run(16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 17);
      run(16'd12345, 16'd12345, 16'd1, 16'd0, 1'b0, 17);
      run(16'd7, 16'd100, 16'd0, 16'd7, 1'b0, 17);

      // Back-to-back: second start lands in the DONE cycle of the first.
      repeat (3) @(posedge clk); #1;
      run(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
      run(16'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 17);

      // Start during RUN is ignored; a reset mid-run aborts with no done.
      repeat (2) @(posedge clk); #1;
      start = 1'b1; dvd = 16'd100; dvs = 16'd7;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      repeat (4) begin @(posedge clk); #1; n++; end
      start = 1'b1; dvd = 16'd9; dvs = 16'd3;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      chk("ignored_start_latency", n, 17);
      chk("ignored_start_quot", quot, 16'd14);
      chk("ignored_start_rem",  rem,  16'd2);
      start = 1'b1; dvd = 16'd200; dvs = 16'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      chk("abort_quot", quot, 16'h0);
      chk("abort_rem",  rem,  16'h0);
      chk("abort_busy", busy, 1'b0);
      dcount = 0;
      repeat (25) begin @(posedge clk); #1; if (done) dcount++; end
      chk("abort_no_done", dcount, 0);

`ifdef DIV_SIGNED_EN
      run(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 17);
      run(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0, 17);
      run(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 17);
      run(16'hFF9C, 16'hFFF9, 16'd14, 16'hFFFE, 1'b0, 17);
      run(16'hFFFB, 16'd0, 16'hFFFF, 16'hFFFB, 1'b1, 1);
`else
      run(16'h8000, 16'hFFFF, 16'd0, 16'h8000, 1'b0, 17);
      run(16'hFFFE, 16'h00FF, 16'd256, 16'd254, 1'b0, 17);
      run(16'hFFFF, 16'h8000, 16'd1, 16'h7FFF, 1'b0, 17);
`endif
      repeat (5) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
